// File: rtl/fft_seq_pkg.sv
// Shared types and default sizing for the FFT frame sequencer.
package fft_seq_pkg;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefN          = 16;
  localparam int unsigned DefFftLatency = 4;

  typedef enum logic [1:0] {
    StLoad,
    StCompute,
    StDrain
  } seq_state_e;

endpackage

// File: rtl/fft_frame_buf.sv
// N-entry complex frame store: single-entry writes for sample collection,
// whole-frame load for result capture. Contents are deliberately not reset.
module fft_frame_buf #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned Depth     = 16
) (
  input  logic                         clk_i,
  input  logic                         wr_en_i,
  input  logic [$clog2(Depth)-1:0]     wr_idx_i,
  input  logic [DataWidth-1:0]         wr_re_i,
  input  logic [DataWidth-1:0]         wr_im_i,
  input  logic                         load_en_i,
  input  logic [Depth*DataWidth-1:0]   load_re_i,
  input  logic [Depth*DataWidth-1:0]   load_im_i,
  output logic [Depth*DataWidth-1:0]   re_o,
  output logic [Depth*DataWidth-1:0]   im_o
);

  logic [Depth*DataWidth-1:0] re_q;
  logic [Depth*DataWidth-1:0] im_q;

  // Frame load takes priority over a single-entry write.
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      re_q <= load_re_i;
      im_q <= load_im_i;
    end else if (wr_en_i) begin
      re_q[wr_idx_i*DataWidth +: DataWidth] <= wr_re_i;
      im_q[wr_idx_i*DataWidth +: DataWidth] <= wr_im_i;
    end
  end

  assign re_o = re_q;
  assign im_o = im_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer around a parallel FFT: collects N samples, holds the frame
// for FFT_LATENCY enabled cycles, captures results and streams them out.
// Optional: define FFT_SEQ_FRAME_CNT_EN to add the frame_cnt output.
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned N           = DefN,
  parameter int unsigned FFT_LATENCY = DefFftLatency
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_re,
  input  logic signed [DATA_WIDTH-1:0] s_im,
  input  logic                         s_last,
  output logic                         fft_enable,
  output logic [N*DATA_WIDTH-1:0]      fft_zr,
  output logic [N*DATA_WIDTH-1:0]      fft_zi,
  input  logic [N*DATA_WIDTH-1:0]      fft_Zr,
  input  logic [N*DATA_WIDTH-1:0]      fft_Zi,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [DATA_WIDTH-1:0] m_re,
  output logic signed [DATA_WIDTH-1:0] m_im,
  output logic [$clog2(N)-1:0]         m_index,
  output logic                         m_last,
  output logic                         frame_err,
  output logic                         busy
`ifdef FFT_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]                  frame_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = (FFT_LATENCY > 1) ? $clog2(FFT_LATENCY) : 1;

  seq_state_e state_q, state_d;

  logic [IdxW-1:0]              wr_idx_q, wr_idx_d;
  logic [IdxW-1:0]              rd_idx_q, rd_idx_d;
  logic [IdxW-1:0]              m_index_q, m_index_d;
  logic [IdxW-1:0]              rd_sel;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic                         fft_enable_q, fft_enable_d;
  logic                         m_valid_q, m_valid_d;
  logic                         m_last_q, m_last_d;
  logic                         frame_err_q, frame_err_d;
  logic signed [DATA_WIDTH-1:0] m_re_q, m_re_d;
  logic signed [DATA_WIDTH-1:0] m_im_q, m_im_d;
  logic                         ibuf_we;
  logic                         obuf_load;
  logic [N*DATA_WIDTH-1:0]      obuf_re;
  logic [N*DATA_WIDTH-1:0]      obuf_im;

  fft_frame_buf #(
    .DataWidth (DATA_WIDTH),
    .Depth     (N)
  ) u_ibuf (
    .clk_i     (clk),
    .wr_en_i   (ibuf_we),
    .wr_idx_i  (wr_idx_q),
    .wr_re_i   (s_re),
    .wr_im_i   (s_im),
    .load_en_i (1'b0),
    .load_re_i ('0),
    .load_im_i ('0),
    .re_o      (fft_zr),
    .im_o      (fft_zi)
  );

  fft_frame_buf #(
    .DataWidth (DATA_WIDTH),
    .Depth     (N)
  ) u_obuf (
    .clk_i     (clk),
    .wr_en_i   (1'b0),
    .wr_idx_i  ('0),
    .wr_re_i   ('0),
    .wr_im_i   ('0),
    .load_en_i (obuf_load),
    .load_re_i (fft_Zr),
    .load_im_i (fft_Zi),
    .re_o      (obuf_re),
    .im_o      (obuf_im)
  );

  // Bin to present next: the current one when priming, the following one on a handshake.
  assign rd_sel = m_valid_q ? rd_idx_q + 1'b1 : rd_idx_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    cnt_d        = cnt_q;
    fft_enable_d = 1'b0;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    m_index_d    = m_index_q;
    m_re_d       = m_re_q;
    m_im_d       = m_im_q;
    frame_err_d  = 1'b0;
    ibuf_we      = 1'b0;
    obuf_load    = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (s_valid) begin
          ibuf_we = 1'b1;
          if (wr_idx_q == IdxW'(N - 1)) begin
            wr_idx_d     = '0;
            cnt_d        = '0;
            fft_enable_d = 1'b1;
            frame_err_d  = ~s_last;
            state_d      = StCompute;
          end else if (s_last) begin
            // Short frame: drop what was collected.
            wr_idx_d    = '0;
            frame_err_d = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      StCompute: begin
        if (cnt_q == CntW'(FFT_LATENCY - 1)) begin
          obuf_load = 1'b1;
          rd_idx_d  = '0;
          state_d   = StDrain;
        end else begin
          cnt_d        = cnt_q + 1'b1;
          fft_enable_d = 1'b1;
        end
      end
      StDrain: begin
        if (!m_valid_q || m_ready) begin
          if (m_valid_q && m_last_q) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            rd_idx_d  = '0;
            state_d   = StLoad;
          end else begin
            m_valid_d = 1'b1;
            rd_idx_d  = rd_sel;
            m_index_d = rd_sel;
            m_re_d    = obuf_re[rd_sel*DATA_WIDTH +: DATA_WIDTH];
            m_im_d    = obuf_im[rd_sel*DATA_WIDTH +: DATA_WIDTH];
            m_last_d  = (rd_sel == IdxW'(N - 1));
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLoad;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      cnt_q        <= '0;
      fft_enable_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_index_q    <= '0;
      m_re_q       <= '0;
      m_im_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      cnt_q        <= cnt_d;
      fft_enable_q <= fft_enable_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_index_q    <= m_index_d;
      m_re_q       <= m_re_d;
      m_im_q       <= m_im_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Count completed drains; wraps naturally at 0xFFFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (m_valid_q && m_ready && m_last_q) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign s_ready    = (state_q == StLoad);
  assign busy       = (state_q != StLoad);
  assign fft_enable = fft_enable_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_index    = m_index_q;
  assign m_re       = m_re_q;
  assign m_im       = m_im_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer with a queue-based frame model.
// The FFT stand-in is bin k: re = z[N-1-k].re ^ 0x5A5A, im = z[k].im + k,
// forced to zero whenever fft_enable is low.
module tb_fft_frame_sequencer;

  localparam int unsigned W  = 16;
  localparam int unsigned N  = 16;
  localparam int unsigned L  = 4;
  localparam int unsigned IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_re;
  logic [W-1:0]   s_im;
  logic           s_last;
  logic           fft_enable;
  logic [N*W-1:0] fft_zr;
  logic [N*W-1:0] fft_zi;
  logic [N*W-1:0] fft_Zr;
  logic [N*W-1:0] fft_Zi;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_re;
  logic [W-1:0]   m_im;
  logic [IW-1:0]  m_index;
  logic           m_last;
  logic           frame_err;
  logic           busy;
`ifdef FFT_SEQ_FRAME_CNT_EN
  logic [15:0]    frame_cnt;
`endif

  fft_frame_sequencer #(
    .DATA_WIDTH  (W),
    .N           (N),
    .FFT_LATENCY (L)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_re       (s_re),
    .s_im       (s_im),
    .s_last     (s_last),
    .fft_enable (fft_enable),
    .fft_zr     (fft_zr),
    .fft_zi     (fft_zi),
    .fft_Zr     (fft_Zr),
    .fft_Zi     (fft_Zi),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_re       (m_re),
    .m_im       (m_im),
    .m_index    (m_index),
    .m_last     (m_last),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef FFT_SEQ_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FFT stand-in, only producing data while enabled.
  always_comb begin
    fft_Zr = '0;
    fft_Zi = '0;
    for (int k = 0; k < N; k++) begin
      if (fft_enable) begin
        fft_Zr[k*W +: W] = fft_zr[(N-1-k)*W +: W] ^ 16'h5A5A;
        fft_Zi[k*W +: W] = fft_zi[k*W +: W] + W'(k);
      end
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [N*W-1:0] got,
                          input logic [N*W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state.
  typedef struct {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [IW-1:0] idx;
    logic          last;
  } bin_t;
  typedef struct {
    int t_first;
    int t_last;
  } lat_t;

  bin_t           exp_q[$];
  lat_t           lat_q[$];
  logic [W-1:0]   cur_re[$];
  logic [W-1:0]   cur_im[$];
  int             cur_t0;
  logic [N*W-1:0] frm_zr;
  logic [N*W-1:0] frm_zi;
  bit             err_exp   = 1'b0;
  bit             lat_done  = 1'b0;
  int             en_run    = 0;
  int             cyc       = 0;
  int unsigned    cnt_model = 0;
  int             rdy_mode  = 0;
  int             pat_i     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and model, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      lat_q.delete();
      cur_re.delete();
      cur_im.delete();
      err_exp   = 1'b0;
      lat_done  = 1'b0;
      en_run    = 0;
      cnt_model = 0;
    end else begin
      check_eq("frame_err", frame_err, err_exp);
      check_eq("s_ready", s_ready, exp_q.size() == 0);
      check_eq("busy", busy, exp_q.size() != 0);
      if (fft_enable) begin
        en_run++;
        check_eq("fft_en_pending", exp_q.size() != 0, 1'b1);
        check_eq("fft_zr", fft_zr, frm_zr);
        check_eq("fft_zi", fft_zi, frm_zi);
      end else if (en_run != 0) begin
        check_eq("fft_en_len", en_run, L);
        en_run = 0;
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("m_valid_spurious", m_valid, 1'b0);
        end else begin
          if (!lat_done && lat_q.size() > 0) begin
            lat_done = 1'b1;
            if (lat_q[0].t_last - lat_q[0].t_first == N - 1)
              check_eq("lat_first", cyc - lat_q[0].t_first, N + L + 1);
            check_eq("lat_last", cyc - lat_q[0].t_last, L + 2);
          end
          check_eq("m_re", m_re, exp_q[0].re);
          check_eq("m_im", m_im, exp_q[0].im);
          check_eq("m_index", m_index, exp_q[0].idx);
          check_eq("m_last", m_last, exp_q[0].last);
          if (m_ready) begin
            if (exp_q[0].last) begin
              cnt_model++;
              if (lat_q.size() > 0) void'(lat_q.pop_front());
              lat_done = 1'b0;
            end
            void'(exp_q.pop_front());
          end
        end
      end
      err_exp = 1'b0;
      if (s_valid && s_ready) begin
        if (cur_re.size() == 0) cur_t0 = cyc;
        cur_re.push_back(s_re);
        cur_im.push_back(s_im);
        if (cur_re.size() == N) begin
          for (int k = 0; k < N; k++) begin
            bin_t b;
            frm_zr[k*W +: W] = cur_re[k];
            frm_zi[k*W +: W] = cur_im[k];
            b.re   = cur_re[N-1-k] ^ 16'h5A5A;
            b.im   = cur_im[k] + W'(k);
            b.idx  = IW'(k);
            b.last = (k == N - 1);
            exp_q.push_back(b);
          end
          lat_q.push_back('{t_first: cur_t0, t_last: cyc});
          err_exp = !s_last;
          cur_re.delete();
          cur_im.delete();
        end else if (s_last) begin
          err_exp = 1'b1;
          cur_re.delete();
          cur_im.delete();
        end
      end
    end
  end

  // Consumer ready: always, random, or the 1,0,0,1 pattern.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(1));
        default: begin
          m_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
          pat_i++;
        end
      endcase
    end
  end

  // Send len beats; last_pos is the 1-based beat carrying s_last (0: none).
  task automatic send_frame(input int len, input int last_pos, input int gap_pct,
                            input bit fixed);
    bit acc;
    int waited;
    for (int i = 0; i < len; i++) begin
      while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_valid = 1'b1;
      s_re    = fixed ? 16'h7FFF : W'($urandom);
      s_im    = fixed ? 16'h7FFF : W'($urandom);
      s_last  = (i + 1 == last_pos);
      acc     = 1'b0;
      waited  = 0;
      while (!acc && waited < 500) begin
        acc = s_ready;
        @(posedge clk);
        #1;
        waited++;
      end
      check_eq("s_accept", acc, 1'b1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain_done", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_fft_enable", fft_enable, 1'b0);
    check_eq("rst_s_ready", s_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_re    = '0;
    s_im    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_m_valid", m_valid, 1'b0);
    check_eq("reset_fft_enable", fft_enable, 1'b0);
    check_eq("reset_frame_err", frame_err, 1'b0);
    check_eq("reset_m_last", m_last, 1'b0);
    check_eq("reset_m_re", m_re, 16'h0);
    check_eq("reset_m_im", m_im, 16'h0);
    check_eq("reset_m_index", m_index, 4'h0);
    check_eq("reset_s_ready", s_ready, 1'b1);
    check_eq("reset_busy", busy, 1'b0);
    rst = 1'b0;

    // Full-scale frame, contiguous, consumer always ready.
    rdy_mode = 0;
    send_frame(N, N, 0, 1'b1);
    wait_idle();

    // Backpressure 1,0,0,1.
    rdy_mode = 2;
    send_frame(N, N, 0, 1'b0);
    wait_idle();

    // Short frame then a normal one.
    rdy_mode = 0;
    send_frame(5, 5, 0, 1'b0);
    send_frame(N, N, 0, 1'b0);
    wait_idle();

    // Full frame without s_last.
    send_frame(N, 0, 0, 1'b0);
    wait_idle();

    // Randomized mix.
    for (int f = 0; f < 10; f++) begin
      int kind;
      kind     = $urandom_range(5);
      rdy_mode = $urandom_range(2);
      if (kind == 4) begin
        n = $urandom_range(1, N - 1);
        send_frame(n, n, $urandom_range(40), 1'b0);
      end else if (kind == 5) begin
        send_frame(N, 0, $urandom_range(40), 1'b0);
      end else begin
        send_frame(N, N, $urandom_range(40), 1'b0);
      end
      wait_idle();
    end

    // Reset during COMPUTE.
    rdy_mode = 0;
    send_frame(N, N, 0, 1'b0);
    check_eq("compute_en", fft_enable, 1'b1);
    pulse_reset();

    // Reset while bin 7 is presented.
    send_frame(N, N, 0, 1'b0);
    n = 0;
    while (!(m_valid && m_index == 4'd7) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("reach_bin7", m_index, 4'd7);
    pulse_reset();

    // Three clean frames after reset.
    for (int f = 0; f < 3; f++) begin
      rdy_mode = (f == 1) ? 1 : 0;
      send_frame(N, N, 10, 1'b0);
      wait_idle();
    end
`ifdef FFT_SEQ_FRAME_CNT_EN
    check_eq("frame_cnt", frame_cnt, 16'd3);
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion",
             n_checks);
    $fatal(1, "watchdog");
  end

endmodule
